pc_fetch_ctrl: RTL and testbench

- Fetch-stage sequencer for the pipelined MIPS core.
- Drives the enable and next-PC select inputs of the pc block (PCSrc, PCBranch) and the IF/ID register controls.
- Arbitrates between three sources: the instruction-memory handshake, load-use stalls from the hazard unit, and branch redirects from EX.
- Holds a pending branch redirect across instruction-memory wait states, so no taken branch is lost.

---
 rtl/pc_fetch_ctrl.sv | 166 ++++++++++++++++
 tb/tb_pc_fetch_ctrl.sv | 191 +++++++++++++++++++
 2 files changed

// File: rtl/pc_fetch_ctrl.sv
// -----------------------------------------------------------------------------
// pc_fetch_ctrl -- fetch-stage sequencer for the pipelined MIPS core.
//
// Drives the pc block's update enable and next-PC select (PCSrc, PCBranch),
// and the IF/ID register's write enable and flush. It arbitrates between the
// instruction-memory handshake, load-use stalls and branch redirects from EX.
// A taken branch that arrives while memory is waiting, or while the fetch is
// held, is remembered until its redirect can be issued.
//
// Ports
//   clk            in   core clock, rising edge
//   rst            in   synchronous active-high reset
//   stall_req      in   load-use stall request from the hazard unit
//   branch_taken   in   one-cycle pulse: branch resolved taken in EX
//   branch_target  in   [31:0] target address, valid with branch_taken
//   imem_ack       in   instruction word for the current PC is available
//   imem_req       out  fetch request to instruction memory
//   pc_en          out  PC register update enable
//   PCSrc          out  0: pcplus4addr, 1: PCBranch
//   PCBranch       out  [31:0] redirect address presented to pc
//   ifid_en        out  IF/ID register write enable
//   ifid_flush     out  load a bubble into IF/ID
//   fetch_timeout  out  sticky: ACK_TIMEOUT consecutive no-ack cycles seen
// -----------------------------------------------------------------------------
module pc_fetch_ctrl #(
  parameter int unsigned RESET_WAIT  = 2,   // 1..15
  parameter int unsigned ACK_TIMEOUT = 15   // 1..255
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        stall_req,
  input  logic        branch_taken,
  input  logic [31:0] branch_target,
  input  logic        imem_ack,
  output logic        imem_req,
  output logic        pc_en,
  output logic        PCSrc,
  output logic [31:0] PCBranch,
  output logic        ifid_en,
  output logic        ifid_flush,
  output logic        fetch_timeout
);

  typedef enum logic [1:0] {
    ST_BOOT  = 2'd0,
    ST_FETCH = 2'd1,
    ST_HOLD  = 2'd2
  } state_t;

  localparam logic [3:0] BOOT_LAST = 4'(RESET_WAIT - 1);
  localparam logic [7:0] WAIT_MAX  = 8'(ACK_TIMEOUT);

  state_t      state_q, state_d;
  logic [3:0]  boot_cnt_q, boot_cnt_d;
  logic [7:0]  wait_cnt_q, wait_cnt_d;
  logic        br_pend_q, br_pend_d;
  logic [31:0] br_tgt_q, br_tgt_d;
  logic        timeout_q, timeout_d;

  // A redirect is wanted if a branch resolves now or one is still pending;
  // a fresh pulse always carries the newest target.
  logic        eb;
  logic [31:0] et;
  logic        redirect;

  assign eb = branch_taken | br_pend_q;
  assign et = branch_taken ? branch_target : br_tgt_q;

  always_comb begin
    state_d    = state_q;
    boot_cnt_d = boot_cnt_q;
    wait_cnt_d = '0;              // cleared on ack and whenever not in FETCH
    br_pend_d  = br_pend_q;
    br_tgt_d   = br_tgt_q;
    timeout_d  = timeout_q;
    redirect   = 1'b0;
    imem_req   = 1'b0;
    pc_en      = 1'b0;
    PCSrc      = 1'b0;
    ifid_en    = 1'b0;
    ifid_flush = 1'b0;

    case (state_q)
      ST_BOOT: begin
        if (boot_cnt_q == BOOT_LAST) begin
          boot_cnt_d = '0;
          state_d    = ST_FETCH;
        end else begin
          boot_cnt_d = boot_cnt_q + 4'd1;
        end
      end

      ST_FETCH: begin
        imem_req = 1'b1;
        if (imem_ack) begin
          if (eb) begin
            redirect = 1'b1;          // branch beats stall
          end else if (stall_req) begin
            state_d = ST_HOLD;
          end else begin
            pc_en   = 1'b1;
            ifid_en = 1'b1;
          end
        end else begin
          // Bubble into ID while waiting, unless ID itself is frozen.
          ifid_flush = !stall_req;
          wait_cnt_d = (wait_cnt_q == WAIT_MAX) ? wait_cnt_q : wait_cnt_q + 8'd1;
          if (wait_cnt_d == WAIT_MAX) begin
            timeout_d = 1'b1;
          end
        end
      end

      ST_HOLD: begin
        if (eb) begin
          redirect = 1'b1;
          state_d  = ST_FETCH;
        end else if (!stall_req) begin
          state_d = ST_FETCH;         // held PC is fetched again
        end
      end

      default: begin
        state_d = ST_BOOT;
      end
    endcase

    if (redirect) begin
      pc_en      = 1'b1;
      PCSrc      = 1'b1;
      ifid_flush = 1'b1;
      ifid_en    = 1'b0;
    end

    // Branches are only tracked once fetching has begun. Issuing the
    // redirect consumes the pending branch, including one arriving this cycle.
    if (state_q != ST_BOOT) begin
      if (branch_taken) begin
        br_tgt_d = branch_target;
      end
      br_pend_d = redirect ? 1'b0 : (branch_taken | br_pend_q);
    end
  end

  assign PCBranch      = PCSrc ? et : br_tgt_q;
  assign fetch_timeout = timeout_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= ST_BOOT;
      boot_cnt_q <= '0;
      wait_cnt_q <= '0;
      br_pend_q  <= 1'b0;
      br_tgt_q   <= '0;
      timeout_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      boot_cnt_q <= boot_cnt_d;
      wait_cnt_q <= wait_cnt_d;
      br_pend_q  <= br_pend_d;
      br_tgt_q   <= br_tgt_d;
      timeout_q  <= timeout_d;
    end
  end

endmodule

// File: tb/tb_pc_fetch_ctrl.sv
// -----------------------------------------------------------------------------
// tb_pc_fetch_ctrl -- directed, self-checking bench for pc_fetch_ctrl.
// Each step drives one cycle of inputs, pushes the hand-derived expected
// outputs for that cycle into a scoreboard queue, and pops/compares them
// at the falling edge of the same cycle.
// -----------------------------------------------------------------------------
module tb_pc_fetch_ctrl;

  logic        clk;
  logic        rst;
  logic        stall_req;
  logic        branch_taken;
  logic [31:0] branch_target;
  logic        imem_ack;
  logic        imem_req;
  logic        pc_en;
  logic        PCSrc;
  logic [31:0] PCBranch;
  logic        ifid_en;
  logic        ifid_flush;
  logic        fetch_timeout;

  pc_fetch_ctrl #(
    .RESET_WAIT  (2),
    .ACK_TIMEOUT (15)
  ) dut (
    .clk           (clk),
    .rst           (rst),
    .stall_req     (stall_req),
    .branch_taken  (branch_taken),
    .branch_target (branch_target),
    .imem_ack      (imem_ack),
    .imem_req      (imem_req),
    .pc_en         (pc_en),
    .PCSrc         (PCSrc),
    .PCBranch      (PCBranch),
    .ifid_en       (ifid_en),
    .ifid_flush    (ifid_flush),
    .fetch_timeout (fetch_timeout)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct packed {
    logic        req;
    logic        pce;
    logic        src;
    logic [31:0] pcb;
    logic        en;
    logic        fl;
    logic        to;
  } exp_t;

  exp_t sb_q[$];
  int   errors = 0;
  int   checks = 0;
  int   step_no = 0;

  function automatic exp_t ex(input logic req, input logic pce, input logic src,
                              input logic [31:0] pcb, input logic en,
                              input logic fl, input logic to);
    exp_t e;
    e.req = req; e.pce = pce; e.src = src; e.pcb = pcb;
    e.en  = en;  e.fl  = fl;  e.to  = to;
    return e;
  endfunction

  // Shorthands for the output patterns the block can produce.
  function automatic exp_t e_boot();
    return ex(1'b0, 1'b0, 1'b0, 32'h0, 1'b0, 1'b0, 1'b0);
  endfunction
  function automatic exp_t e_stream(input logic [31:0] pcb, input logic to);
    return ex(1'b1, 1'b1, 1'b0, pcb, 1'b1, 1'b0, to);
  endfunction
  function automatic exp_t e_wait(input logic [31:0] pcb, input logic fl, input logic to);
    return ex(1'b1, 1'b0, 1'b0, pcb, 1'b0, fl, to);
  endfunction
  function automatic exp_t e_redir(input logic req, input logic [31:0] pcb);
    return ex(req, 1'b1, 1'b1, pcb, 1'b0, 1'b1, 1'b0);
  endfunction
  function automatic exp_t e_hold(input logic req, input logic [31:0] pcb);
    return ex(req, 1'b0, 1'b0, pcb, 1'b0, 1'b0, 1'b0);
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    checks++;
    assert (obs === expv) else begin
      errors++;
      $error("FAIL %s step=%0d got=%h expected=%h", tag, step_no, obs, expv);
    end
  endtask

  task automatic step(input string name, input logic r, input logic st,
                      input logic br, input logic [31:0] tg, input logic ack,
                      input exp_t e);
    exp_t x;
    @(posedge clk);
    #1;
    rst           = r;
    stall_req     = st;
    branch_taken  = br;
    branch_target = tg;
    imem_ack      = ack;
    sb_q.push_back(e);
    @(negedge clk);
    step_no++;
    if (sb_q.size() == 0) begin
      errors++;
      $display("FAIL scoreboard_empty step=%0d got=0 expected=1", step_no);
    end else begin
      x = sb_q.pop_front();
      check({name, ".imem_req"},      {31'b0, imem_req},      {31'b0, x.req});
      check({name, ".pc_en"},         {31'b0, pc_en},         {31'b0, x.pce});
      check({name, ".PCSrc"},         {31'b0, PCSrc},         {31'b0, x.src});
      check({name, ".PCBranch"},      PCBranch,               x.pcb);
      check({name, ".ifid_en"},       {31'b0, ifid_en},       {31'b0, x.en});
      check({name, ".ifid_flush"},    {31'b0, ifid_flush},    {31'b0, x.fl});
      check({name, ".fetch_timeout"}, {31'b0, fetch_timeout}, {31'b0, x.to});
      check({name, ".excl"},          {31'b0, ifid_en & ifid_flush}, 32'h0);
    end
    $display("step %0d %s: rst=%b stall=%b br=%b tgt=%h ack=%b -> req=%b pc_en=%b src=%b pcb=%h en=%b fl=%b to=%b",
             step_no, name, r, st, br, tg, ack, imem_req, pc_en, PCSrc, PCBranch,
             ifid_en, ifid_flush, fetch_timeout);
  endtask

  initial begin
    rst = 1'b1; stall_req = 1'b0; branch_taken = 1'b0;
    branch_target = 32'h0; imem_ack = 1'b0;

    // Reset and boot: two BOOT cycles after rst drops, then fetching starts.
    step("rst0",  1'b1, 1'b0, 1'b0, 32'h0, 1'b0, e_boot());
    step("rst1",  1'b1, 1'b0, 1'b0, 32'h0, 1'b0, e_boot());
    step("boot0", 1'b0, 1'b0, 1'b0, 32'h0, 1'b1, e_boot());
    step("boot1", 1'b0, 1'b0, 1'b0, 32'h0, 1'b1, e_boot());

    // Zero-wait stream.
    for (int i = 0; i < 3; i++)
      step("stream", 1'b0, 1'b0, 1'b0, 32'h0, 1'b1, e_stream(32'h0, 1'b0));

    // Branch arrives during memory wait, redirect issued on the ack.
    step("bw_w1",  1'b0, 1'b0, 1'b1, 32'h40, 1'b0, e_wait(32'h0,  1'b1, 1'b0));
    step("bw_w2",  1'b0, 1'b0, 1'b0, 32'h0,  1'b0, e_wait(32'h40, 1'b1, 1'b0));
    step("bw_w3",  1'b0, 1'b0, 1'b0, 32'h0,  1'b0, e_wait(32'h40, 1'b1, 1'b0));
    step("bw_ack", 1'b0, 1'b0, 1'b0, 32'h0,  1'b1, e_redir(1'b1, 32'h40));
    step("bw_nxt", 1'b0, 1'b0, 1'b0, 32'h0,  1'b1, e_stream(32'h40, 1'b0));

    // Branch and stall together on an ack: redirect wins, HOLD never entered.
    step("coll",     1'b0, 1'b1, 1'b1, 32'h100, 1'b1, e_redir(1'b1, 32'h100));
    step("coll_nxt", 1'b0, 1'b0, 1'b0, 32'h0,   1'b1, e_stream(32'h100, 1'b0));

    // Stall into HOLD, then two branch pulses.
    step("st_in",  1'b0, 1'b1, 1'b0, 32'h0,  1'b1, e_hold(1'b1, 32'h100));
    step("st_hld", 1'b0, 1'b1, 1'b0, 32'h0,  1'b1, e_hold(1'b0, 32'h100));
    step("hb_10",  1'b0, 1'b1, 1'b1, 32'h10, 1'b0, e_redir(1'b0, 32'h10));
    step("hb_20",  1'b0, 1'b0, 1'b1, 32'h20, 1'b0, e_wait(32'h10, 1'b1, 1'b0));
    step("hb_ack", 1'b0, 1'b0, 1'b0, 32'h0,  1'b1, e_redir(1'b1, 32'h20));
    step("hb_nxt", 1'b0, 1'b0, 1'b0, 32'h0,  1'b1, e_stream(32'h20, 1'b0));

    // Both pulses during a FETCH wait: later target wins on ack.
    step("fb_10",  1'b0, 1'b0, 1'b1, 32'h10, 1'b0, e_wait(32'h20, 1'b1, 1'b0));
    step("fb_20",  1'b0, 1'b0, 1'b1, 32'h20, 1'b0, e_wait(32'h10, 1'b1, 1'b0));
    step("fb_ack", 1'b0, 1'b0, 1'b0, 32'h0,  1'b1, e_redir(1'b1, 32'h20));
    step("fb_nxt", 1'b0, 1'b0, 1'b0, 32'h0,  1'b1, e_stream(32'h20, 1'b0));

    // HOLD released by stall dropping, then a wait with ID stalled (no bubble).
    step("h_in",   1'b0, 1'b1, 1'b0, 32'h0, 1'b1, e_hold(1'b1, 32'h20));
    step("h_rel",  1'b0, 1'b0, 1'b0, 32'h0, 1'b1, e_hold(1'b0, 32'h20));
    step("h_ref",  1'b0, 1'b0, 1'b0, 32'h0, 1'b1, e_stream(32'h20, 1'b0));
    step("w_stl",  1'b0, 1'b1, 1'b0, 32'h0, 1'b0, e_wait(32'h20, 1'b0, 1'b0));
    step("w_end",  1'b0, 1'b0, 1'b0, 32'h0, 1'b1, e_stream(32'h20, 1'b0));

    // Timeout: flag is registered as the 15th consecutive wait cycle closes.
    for (int i = 1; i <= 15; i++)
      step("tmo_w", 1'b0, 1'b0, 1'b0, 32'h0, 1'b0, e_wait(32'h20, 1'b1, 1'b0));
    step("tmo_16", 1'b0, 1'b0, 1'b0, 32'h0, 1'b0, e_wait(32'h20, 1'b1, 1'b1));
    step("tmo_17", 1'b0, 1'b0, 1'b0, 32'h0, 1'b0, e_wait(32'h20, 1'b1, 1'b1));
    step("tmo_a1", 1'b0, 1'b0, 1'b0, 32'h0, 1'b1, e_stream(32'h20, 1'b1));
    step("tmo_a2", 1'b0, 1'b0, 1'b0, 32'h0, 1'b1, e_stream(32'h20, 1'b1));

    // Reset mid-operation with a branch in flight: everything is dropped.
    step("mrst",   1'b1, 1'b0, 1'b1, 32'hDEAD0000, 1'b0, e_wait(32'h20, 1'b1, 1'b1));
    step("mboot0", 1'b0, 1'b0, 1'b0, 32'h0, 1'b1, e_boot());
    step("mboot1", 1'b0, 1'b0, 1'b0, 32'h0, 1'b1, e_boot());
    step("mfetch", 1'b0, 1'b0, 1'b0, 32'h0, 1'b1, e_stream(32'h0, 1'b0));

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
